error_evt_arbiter: RTL and testbench
====================================

// Module: error_evt_arbiter
// PURPOSE
//  Multi-source front end for the central error logger's event port.
//  Each of NREQ subsystems owns a one-entry holding slot. The block arbitrates the pending
//  slots (fatal class first, round-robin within a class) into a single registered event
//  stream. It tags each event with the requester's source ID and obeys the logger's
//  evt_valid/evt_ready backpressure.
// PARAMETERS
//  NREQ      4         number of requesters (2..16)
//  SRC_BASE  16'h0100  evt_src = SRC_BASE + requester index
// PORTS
//  clk            in   1        single clock; all logic on posedge
//  rst_n          in   1        reset, asynchronous, active-low
//  req_valid      in   NREQ     per-requester event valid
//  req_ready      out  NREQ     per-requester slot free (1 = capture this cycle)
//  req_sev        in   NREQ*4   severity, requester i at [4i+:4]
//  req_code       in   NREQ*8   error code, [8i+:8]
//  req_data0      in   NREQ*32  payload word 0, [32i+:32]
//  req_data1      in   NREQ*32  payload word 1, [32i+:32]
//  evt_valid      out  1        event to logger valid
//  evt_ready      in   1        logger accepts
//  evt_severity   out  4        severity of the granted event
//  evt_code       out  8        code of the granted event
//  evt_src        out  16       SRC_BASE + granted index (mod 2^16)
//  evt_data0      out  32       payload word 0 of the granted event
//  evt_data1      out  32       payload word 1 of the granted event
//  busy           out  1        any slot valid OR evt_valid
// BEHAVIOUR
//  Reset values (async, on rst_n low)
//   - All slots empty, so req_ready = all 1s.
//   - evt_valid = 0; evt_* payload = 0; busy = 0.
//   - RR pointer = NREQ-1, so requester 0 wins first.
//   - Pending events are discarded. Reset mid-transfer is legal.
//  Slots
//   - req_ready[i] = ~slot_vld[i], driven from a register.
//   - req_valid[i] & req_ready[i] at edge T captures sev/code/data0/data1; slot_vld[i] = 1 from T+1.
//   - A slot clears in the cycle it is loaded into the output register.
//   - req_ready[i] returns to 1 the following cycle.
//  Output register
//   - Load condition: LOAD = (~evt_valid | evt_ready) & |slot_vld.
//   - On LOAD: the winner's payload enters the output register and evt_valid = 1.
//   - If ~LOAD & evt_valid & evt_ready: evt_valid goes to 0.
//   - Once evt_valid = 1, evt_valid and all evt_* outputs hold stable until evt_ready is sampled high.
//   - Back-to-back: on a handshake with another slot pending, the next event loads the same cycle
//     (sustained 1 event/cycle).
//  Latency
//   - Request capture at T gives earliest evt_valid at T+2.
//  Arbitration (combinational on registered slot state)
//   - fatal_mask = slot_vld & (sev == 4'd3).
//   - cand = fatal_mask if nonzero, else slot_vld.
//   - Winner = first set bit of cand searching rr_ptr+1, rr_ptr+2, ... (wrapping modulo NREQ).
//   - On LOAD, rr_ptr = winner. A single shared pointer serves both classes.
//   - Severities 0, 1, 2 and 4..15 are all normal class and are forwarded unchanged.
//  Simultaneous events
//   - A slot captured at edge T is not eligible for arbitration until T+1.
//   - No event is dropped, duplicated or reordered within one requester.
//  Status
//   - busy = |slot_vld | evt_valid, registered-equivalent (no combinational input paths).
// TESTING
//  1. Single event
//     - Stimulus: req1 sev=2 code=8'h5A d0=32'hDEAD_0001 at T; evt_ready=0 until T+5.
//     - Required: evt_valid rises at T+2 with src=16'h0101; payload stable through T+5.
//     - Required: handshake at T+5; req_ready[1] is 0 from T+1 and returns to 1 at T+3.
//  2. Simultaneous normal events
//     - Stimulus: all 4 requesters sev=1 in the same cycle; evt_ready tied 1.
//     - Required: srcs 0x0100, 0x0101, 0x0102, 0x0103 on consecutive cycles; evt_valid then drops.
//  3. Fatal priority
//     - Stimulus: slots 0 and 1 sev=1 and slot 2 sev=3 all pending.
//     - Required: grant order 2, 0, 1. The pointer restarts after 2, so 3 is checked first, then 0.
//  4. Fairness
//     - Stimulus: req0 re-requests every cycle at sev=1; req3 posts one sev=1 event.
//     - Required: req3 is granted no later than after one further req0 grant.
//  5. Backpressure
//     - Stimulus: evt_ready=0 for 20 cycles while every requester posts twice.
//     - Required: req_ready all 0 once the slots fill; output held stable.
//     - Required: after release, exactly 8 events arrive, with none lost or duplicated.
//  6. Reset mid-transfer
//     - Stimulus: rst_n low while evt_valid=1.
//     - Required: evt_valid=0 and req_ready all 1s with no clock edge.
//     - Required: after release, the first of several simultaneous requests granted is requester 0.

Source files
------------

// File: rtl/error_evt_arbiter.sv
// Multi-requester front end for the error logger event port: one holding slot per
// requester, fatal-first round-robin arbitration into a registered valid/ready stream.
module error_evt_arbiter #(
    parameter int          NREQ     = 4,
    parameter logic [15:0] SRC_BASE = 16'h0100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*4-1:0]    req_sev,
    input  logic [NREQ*8-1:0]    req_code,
    input  logic [NREQ*32-1:0]   req_data0,
    input  logic [NREQ*32-1:0]   req_data1,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [3:0]           evt_severity,
    output logic [7:0]           evt_code,
    output logic [15:0]          evt_src,
    output logic [31:0]          evt_data0,
    output logic [31:0]          evt_data1,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] slot_vld;
    logic [NREQ-1:0] slot_vld_nxt;
    logic [NREQ-1:0] rdy_r;
    logic [NREQ-1:0] cap;
    logic [NREQ-1:0] fatal_mask;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] win_oh;
    logic [3:0]      slot_sev  [NREQ];
    logic [7:0]      slot_code [NREQ];
    logic [31:0]     slot_d0   [NREQ];
    logic [31:0]     slot_d1   [NREQ];
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   win;
    logic            found;
    logic            load;

    assign cap       = req_valid & rdy_r;
    assign req_ready = rdy_r;
    assign load      = (~evt_valid | evt_ready) & (|slot_vld);
    assign busy      = (|slot_vld) | evt_valid;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            fatal_mask[i] = slot_vld[i] & (slot_sev[i] == 4'd3);
        end
        cand  = (|fatal_mask) ? fatal_mask : slot_vld;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && cand[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            win_oh[i] = load && (win == PW'(i));
        end
        slot_vld_nxt = (slot_vld & ~win_oh) | cap;
    end

    // Ready stays low for one extra cycle after a slot drains, so it tracks both the
    // current and the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            rdy_r    <= '1;
            rr_ptr   <= PW'(NREQ - 1);
        end else begin
            slot_vld <= slot_vld_nxt;
            rdy_r    <= ~(slot_vld | slot_vld_nxt);
            if (load) begin
                rr_ptr <= win;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (cap[i]) begin
                slot_sev[i]  <= req_sev[4*i +: 4];
                slot_code[i] <= req_code[8*i +: 8];
                slot_d0[i]   <= req_data0[32*i +: 32];
                slot_d1[i]   <= req_data1[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid    <= 1'b0;
            evt_severity <= '0;
            evt_code     <= '0;
            evt_src      <= '0;
            evt_data0    <= '0;
            evt_data1    <= '0;
        end else if (load) begin
            evt_valid    <= 1'b1;
            evt_severity <= slot_sev[win];
            evt_code     <= slot_code[win];
            evt_src      <= SRC_BASE + 16'(win);
            evt_data0    <= slot_d0[win];
            evt_data1    <= slot_d1[win];
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_error_evt_arbiter.sv
// Bench for error_evt_arbiter: directed scenarios plus random traffic, checked every
// cycle against a cycle-level behavioural model and a per-requester scoreboard.
module tb_error_evt_arbiter;

    typedef struct packed {
        logic [3:0]  sev;
        logic [7:0]  code;
        logic [31:0] d0;
        logic [31:0] d1;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   rv = '0;
    logic [3:0]   rdy;
    logic [15:0]  rsev = '0;
    logic [31:0]  rcode = '0;
    logic [127:0] rd0 = '0;
    logic [127:0] rd1 = '0;
    logic         evt_valid;
    logic         er = 1'b0;
    logic [3:0]   evt_severity;
    logic [7:0]   evt_code;
    logic [15:0]  evt_src;
    logic [31:0]  evt_data0;
    logic [31:0]  evt_data1;
    logic         busy;

    int nchk = 0;
    int nerr = 0;

    // Model state
    logic        m_sv [4];
    ev_t         m_sl [4];
    logic [3:0]  m_rdy;
    logic        m_ov;
    ev_t         m_out;
    logic [15:0] m_src;
    int          m_last;

    ev_t  sbq [4][$];
    int   gq[$];
    int   ngr;
    logic [3:0] acc;

    error_evt_arbiter #(.NREQ(4), .SRC_BASE(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(rdy),
        .req_sev(rsev), .req_code(rcode), .req_data0(rd0), .req_data1(rd1),
        .evt_valid(evt_valid), .evt_ready(er), .evt_severity(evt_severity),
        .evt_code(evt_code), .evt_src(evt_src), .evt_data0(evt_data0),
        .evt_data1(evt_data1), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ev_t req_ev(input int i);
        ev_t e;
        e.sev  = rsev[4*i +: 4];
        e.code = rcode[8*i +: 8];
        e.d0   = rd0[32*i +: 32];
        e.d1   = rd1[32*i +: 32];
        return e;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [3:0] s, input logic [7:0] c,
                           input logic [31:0] a, input logic [31:0] b);
        rv[i] = v;
        rsev[4*i +: 4] = s;
        rcode[8*i +: 8] = c;
        rd0[32*i +: 32] = a;
        rd1[32*i +: 32] = b;
    endtask

    task automatic rand_req(input int i, input logic v);
        logic [3:0] s;
        s = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(0, 15));
        set_req(i, v, s, 8'($urandom), $urandom, $urandom);
    endtask

    // Winner: first pending requester cyclically after the last grant, fatal ones preferred.
    function automatic int pick();
        int best = -1;
        for (int k = 1; k <= 4; k++) begin
            int j = (m_last + k) % 4;
            if (best < 0 && m_sv[j] && m_sl[j].sev == 4'd3) best = j;
        end
        for (int k = 1; k <= 4; k++) begin
            int j = (m_last + k) % 4;
            if (best < 0 && m_sv[j]) best = j;
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sv[i] = 1'b0;
            m_sl[i] = '0;
            sbq[i].delete();
        end
        m_rdy  = 4'hF;
        m_ov   = 1'b0;
        m_out  = '0;
        m_src  = 16'h0;
        m_last = 3;
        gq.delete();
        ngr = 0;
    endtask

    task automatic model_update();
        logic old_v [4];
        int w;
        for (int i = 0; i < 4; i++) old_v[i] = m_sv[i];
        w = pick();
        if ((!m_ov || er) && w >= 0) begin
            m_out   = m_sl[w];
            m_src   = 16'h0100 + 16'(w);
            m_ov    = 1'b1;
            m_last  = w;
            m_sv[w] = 1'b0;
        end else if (m_ov && er) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (rv[i] && m_rdy[i]) begin
                m_sv[i] = 1'b1;
                m_sl[i] = req_ev(i);
            end
        end
        for (int i = 0; i < 4; i++) m_rdy[i] = !old_v[i] && !m_sv[i];
    endtask

    task automatic compare_all();
        logic anyv;
        anyv = m_sv[0] | m_sv[1] | m_sv[2] | m_sv[3] | m_ov;
        chk("req_ready", 80'(rdy), 80'(m_rdy));
        chk("evt_valid", 80'(evt_valid), 80'(m_ov));
        chk("busy", 80'(busy), 80'(anyv));
        chk("evt_src", 80'(evt_src), 80'(m_src));
        chk("evt_payload", 80'({evt_severity, evt_code, evt_data0, evt_data1}), 80'(m_out));
    endtask

    // One clock: log handshakes seen before the edge, advance model, compare after.
    task automatic step();
        acc = rv & rdy;
        for (int i = 0; i < 4; i++) if (acc[i]) sbq[i].push_back(req_ev(i));
        if (evt_valid && er) begin
            int s;
            s = int'(evt_src) - 16'h0100;
            ngr++;
            gq.push_back(s);
            if (s < 0 || s > 3 || sbq[s].size() == 0) begin
                chk("sb_unexpected", 80'(evt_src), 80'hFFFF);
            end else begin
                chk("sb_payload", 80'({evt_severity, evt_code, evt_data0, evt_data1}),
                    80'(sbq[s].pop_front()));
            end
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rv = '0;
        er = 1'b0;
        model_reset();
        #1;
        chk("rst_evt_valid", 80'(evt_valid), 80'h0);
        chk("rst_req_ready", 80'(rdy), 80'hF);
        chk("rst_busy", 80'(busy), 80'h0);
        chk("rst_src", 80'(evt_src), 80'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int sent [4];
        logic [47:0] held;
        int n0;

        model_reset();
        do_reset();

        // Single event with delayed accept
        set_req(1, 1'b1, 4'd2, 8'h5A, 32'hDEAD_0001, 32'h1234_5678);
        step();
        chk("t1_rdy_T1", 80'(rdy[1]), 80'h0);
        rv = '0;
        step();
        chk("t1_valid_T2", 80'(evt_valid), 80'h1);
        chk("t1_src_T2", 80'(evt_src), 80'h0101);
        chk("t1_pay_T2", 80'({evt_severity, evt_code, evt_data0}), 80'h25ADEAD0001);
        chk("t1_rdy_T2", 80'(rdy[1]), 80'h0);
        step();
        chk("t1_rdy_T3", 80'(rdy[1]), 80'h1);
        step();
        er = 1'b1;
        chk("t1_hold_T5", 80'({evt_valid, evt_data0}), 80'h1DEAD0001);
        step();
        chk("t1_drop_T6", 80'(evt_valid), 80'h0);
        chk("t1_ngr", 80'(ngr), 80'h1);

        // Simultaneous normal events
        do_reset();
        er = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'd1, 8'(i), $urandom, $urandom);
        step();
        rv = '0;
        for (int c = 0; c < 6; c++) step();
        chk("t2_count", 80'(gq.size()), 80'h4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("t2_order", 80'(gq[i]), 80'(i));
        chk("t2_idle", 80'({evt_valid, busy}), 80'h0);

        // Fatal priority
        do_reset();
        er = 1'b1;
        set_req(0, 1'b1, 4'd1, 8'h10, $urandom, $urandom);
        set_req(1, 1'b1, 4'd1, 8'h11, $urandom, $urandom);
        set_req(2, 1'b1, 4'd3, 8'h12, $urandom, $urandom);
        step();
        rv = '0;
        for (int c = 0; c < 6; c++) step();
        chk("t3_count", 80'(gq.size()), 80'h3);
        if (gq.size() == 3) begin
            chk("t3_first", 80'(gq[0]), 80'h2);
            chk("t3_second", 80'(gq[1]), 80'h0);
            chk("t3_third", 80'(gq[2]), 80'h1);
        end

        // Fairness: req0 requests every cycle, req3 posts once
        do_reset();
        er = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rand_req(0, 1'b1);
            rsev[3:0] = 4'd1;
            step();
        end
        set_req(3, 1'b1, 4'd1, 8'h33, $urandom, $urandom);
        rand_req(0, 1'b1);
        rsev[3:0] = 4'd1;
        step();
        rv[3] = 1'b0;
        n0 = 0;
        begin
            int c = 0;
            while (c < 10 && !(evt_valid && evt_src == 16'h0103)) begin
                if (evt_valid && evt_src == 16'h0100) n0++;
                rand_req(0, 1'b1);
                rsev[3:0] = 4'd1;
                step();
                c++;
            end
        end
        chk("t4_req3_granted", 80'(evt_valid && evt_src == 16'h0103), 80'h1);
        chk("t4_fair", 80'(n0 <= 1), 80'h1);

        // Backpressure: each requester posts twice while the logger stalls
        do_reset();
        for (int i = 0; i < 4; i++) sent[i] = 0;
        held = '0;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 4; i++) rand_req(i, sent[i] < 2);
            step();
            for (int i = 0; i < 4; i++) sent[i] += int'(acc[i]);
            if (c == 2) held = {evt_src, evt_data0};
        end
        chk("t5_full", 80'(rdy), 80'h0);
        chk("t5_stable", 80'({evt_src, evt_data0}), 80'(held));
        er = 1'b1;
        begin
            int c = 0;
            while (c < 40 && ngr < 8) begin
                for (int i = 0; i < 4; i++) rand_req(i, sent[i] < 2);
                step();
                for (int i = 0; i < 4; i++) sent[i] += int'(acc[i]);
                c++;
            end
        end
        rv = '0;
        for (int c = 0; c < 5; c++) step();
        chk("t5_total", 80'(ngr), 80'h8);
        for (int i = 0; i < 4; i++) chk("t5_drained", 80'(sbq[i].size()), 80'h0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) rand_req(i, 1'($urandom_range(0, 1)));
            er = 1'($urandom_range(0, 3) != 0);
            step();
        end
        rv = '0;
        er = 1'b1;
        for (int c = 0; c < 10; c++) step();
        for (int i = 0; i < 4; i++) chk("rnd_drained", 80'(sbq[i].size()), 80'h0);

        // Reset mid-transfer
        set_req(2, 1'b1, 4'd5, 8'h77, $urandom, $urandom);
        er = 1'b0;
        step();
        rv = '0;
        step();
        chk("t6_pre_valid", 80'(evt_valid), 80'h1);
        do_reset();
        er = 1'b1;
        for (int i = 0; i < 4; i++) rand_req(i, 1'b1);
        rsev = 16'h1111;
        step();
        rv = '0;
        for (int c = 0; c < 6; c++) step();
        chk("t6_count", 80'(gq.size()), 80'h4);
        if (gq.size() > 0) chk("t6_first", 80'(gq[0]), 80'h0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
